// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default widths and the
// initiator FSM encoding.
package axi_lite_pkg;

   localparam int AXI_DATA_W = 32;
   localparam int AXI_ADDR_W = 8;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_RSP  = 2'd3
   } mst_state_e;

   function automatic logic resp_is_error(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/m_axi_lite_master_if.sv
// Command/response stream plus AXI4-Lite bus seen by the single-outstanding
// initiator. The master modport is the initiator's view.
interface m_axi_lite_master_if #(
   parameter int DATA_W = axi_lite_pkg::AXI_DATA_W,
   parameter int ADDR_W = axi_lite_pkg::AXI_ADDR_W
);
   localparam int STRB_W = DATA_W / 8;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_wstrb;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_write;
   logic [DATA_W-1:0] rsp_rdata;
   logic [1:0]        rsp_resp;

   logic [ADDR_W-1:0] M_AXI_AWADDR;
   logic [2:0]        M_AXI_AWPROT;
   logic              M_AXI_AWVALID;
   logic              M_AXI_AWREADY;

   logic [DATA_W-1:0] M_AXI_WDATA;
   logic [STRB_W-1:0] M_AXI_WSTRB;
   logic              M_AXI_WVALID;
   logic              M_AXI_WREADY;

   logic [1:0]        M_AXI_BRESP;
   logic              M_AXI_BVALID;
   logic              M_AXI_BREADY;

   logic [ADDR_W-1:0] M_AXI_ARADDR;
   logic [2:0]        M_AXI_ARPROT;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;

   logic [DATA_W-1:0] M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      output cmd_ready,
      output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
      input  rsp_ready,
      output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY,
      output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      input  M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      output M_AXI_RREADY
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      input  cmd_ready,
      input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
      output rsp_ready,
      input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY,
      input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      input  M_AXI_RREADY
   );

endinterface

// File: rtl/m_axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command into an AW+W+B
// or AR+R transaction and hands back the response.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | cmd_ready high, waiting for a command
// ST_WR   | AW/W offered independently, BREADY high until B arrives
// ST_RD   | AR offered, RREADY high until R arrives
// ST_RSP  | rsp_valid high with frozen response until rsp_ready
module m_axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int          C_M_AXI_DATA_WIDTH = AXI_DATA_W,
   parameter int          C_M_AXI_ADDR_WIDTH = AXI_ADDR_W,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input  logic                   M_AXI_ACLK,
   input  logic                   M_AXI_ARESETn,
   m_axi_lite_master_if.master    bus,
   output logic                   timeout_err
);

   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int SW = DW / 8;

   // Counter only has to reach TIMEOUT_CYCLES-1, where it saturates.
   localparam int          CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TC_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TC_LAST);
   localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);

   mst_state_e       state_q, state_d;
   logic             awvalid_q, awvalid_d;
   logic             wvalid_q, wvalid_d;
   logic             bready_q, bready_d;
   logic             arvalid_q, arvalid_d;
   logic             rready_q, rready_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [SW-1:0]    wstrb_q, wstrb_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_write_q, rsp_write_d;
   logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic [1:0]       rsp_resp_q, rsp_resp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETn) begin
      if (!M_AXI_ARESETn) begin
         state_q     <= ST_IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RESP_OKAY;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      cnt_d       = cnt_q;
      timeout_d   = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               addr_d  = bus.cmd_addr;
               wdata_d = bus.cmd_wdata;
               wstrb_d = bus.cmd_wstrb;
               cnt_d   = '0;
               if (bus.cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  bready_d  = 1'b1;
                  state_d   = ST_WR;
               end else begin
                  arvalid_d = 1'b1;
                  rready_d  = 1'b1;
                  state_d   = ST_RD;
               end
            end
         end

         ST_WR: begin
            // AW and W retire independently, in either order.
            if (awvalid_q && bus.M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && bus.M_AXI_WREADY)   wvalid_d  = 1'b0;
            if (bready_q && bus.M_AXI_BVALID) begin
               awvalid_d   = 1'b0;
               wvalid_d    = 1'b0;
               bready_d    = 1'b0;
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = bus.M_AXI_BRESP;
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end
         end

         ST_RD: begin
            if (arvalid_q && bus.M_AXI_ARREADY) arvalid_d = 1'b0;
            if (rready_q && bus.M_AXI_RVALID) begin
               arvalid_d   = 1'b0;
               rready_d    = 1'b0;
               rsp_write_d = 1'b0;
               rsp_rdata_d = bus.M_AXI_RDATA;
               rsp_resp_d  = bus.M_AXI_RRESP;
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end
         end

         ST_RSP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Watchdog only flags; AXI has no way to abort, so the FSM keeps waiting.
      if (state_q == ST_WR || state_q == ST_RD) begin
         if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
         if (WDOG_EN && cnt_q == CNT_LAST) timeout_d = 1'b1;
      end
   end

   assign bus.cmd_ready     = (state_q == ST_IDLE);

   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_write     = rsp_write_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.rsp_resp      = rsp_resp_q;

   assign bus.M_AXI_AWADDR  = addr_q;
   assign bus.M_AXI_AWPROT  = AXI_PROT_DEFAULT;
   assign bus.M_AXI_AWVALID = awvalid_q;
   assign bus.M_AXI_WDATA   = wdata_q;
   assign bus.M_AXI_WSTRB   = wstrb_q;
   assign bus.M_AXI_WVALID  = wvalid_q;
   assign bus.M_AXI_BREADY  = bready_q;
   assign bus.M_AXI_ARADDR  = addr_q;
   assign bus.M_AXI_ARPROT  = AXI_PROT_DEFAULT;
   assign bus.M_AXI_ARVALID = arvalid_q;
   assign bus.M_AXI_RREADY  = rready_q;

   assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_m_axi_lite_master.sv
// Directed bench for m_axi_lite_master: register-slave model with per-channel
// delays, a transaction-level reference checked every cycle, literal pins.
module tb_m_axi_lite_master;
   import axi_lite_pkg::*;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic timeout_err;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   m_axi_lite_master_if #(.DATA_W(32), .ADDR_W(8)) bus ();

   m_axi_lite_master #(
      .C_M_AXI_DATA_WIDTH(32),
      .C_M_AXI_ADDR_WIDTH(8),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .M_AXI_ACLK(clk),
      .M_AXI_ARESETn(rst_n),
      .bus(bus),
      .timeout_err(timeout_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- slave model ----------------
   int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   logic [1:0] b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
   logic [7:0]  s_awaddr = '0, s_araddr = '0;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic [31:0] mem [64];

   initial begin
      int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      logic aw_done, w_done, b_pend, r_pend;
      logic f_aw, f_w, f_b, f_ar, f_r;
      logic [7:0]  t_awaddr, t_araddr;
      logic [31:0] t_wdata;
      logic [3:0]  t_wstrb;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
      bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
      bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
      bus.M_AXI_RVALID = 0; bus.M_AXI_RRESP = 0; bus.M_AXI_RDATA = 0;
      forever begin
         @(negedge clk);
         f_aw = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
         f_w  = bus.M_AXI_WVALID  && bus.M_AXI_WREADY;
         f_b  = bus.M_AXI_BVALID  && bus.M_AXI_BREADY;
         f_ar = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
         f_r  = bus.M_AXI_RVALID  && bus.M_AXI_RREADY;
         t_awaddr = bus.M_AXI_AWADDR; t_araddr = bus.M_AXI_ARADDR;
         t_wdata  = bus.M_AXI_WDATA;  t_wstrb  = bus.M_AXI_WSTRB;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
            bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
            bus.M_AXI_BVALID = 0; bus.M_AXI_RVALID = 0;
         end else begin
            if (f_aw) begin n_aw++; aw_done = 1; s_awaddr = t_awaddr; bus.M_AXI_AWREADY = 0; aw_cnt = 0; end
            if (f_w)  begin n_w++; w_done = 1; s_wdata = t_wdata; s_wstrb = t_wstrb; bus.M_AXI_WREADY = 0; w_cnt = 0; end
            if (f_b)  begin n_b++; bus.M_AXI_BVALID = 0; end
            if (f_ar) begin n_ar++; s_araddr = t_araddr; bus.M_AXI_ARREADY = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; end
            if (f_r)  begin n_r++; bus.M_AXI_RVALID = 0; end
            if (aw_done && w_done) begin
               for (int b = 0; b < 4; b++)
                  if (s_wstrb[b]) mem[s_awaddr[7:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
               aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
            end
            if (b_pend) begin
               if (b_cnt >= b_dly) begin
                  bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = b_resp_cfg; b_pend = 0;
               end else b_cnt++;
            end
            if (r_pend) begin
               if (r_cnt >= r_dly) begin
                  bus.M_AXI_RVALID = 1; bus.M_AXI_RRESP = r_resp_cfg;
                  bus.M_AXI_RDATA = mem[s_araddr[7:2]]; r_pend = 0;
               end else r_cnt++;
            end
            if (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY && !aw_done) begin
               if (aw_cnt >= aw_dly) bus.M_AXI_AWREADY = 1; else aw_cnt++;
            end
            if (bus.M_AXI_WVALID && !bus.M_AXI_WREADY && !w_done) begin
               if (w_cnt >= w_dly) bus.M_AXI_WREADY = 1; else w_cnt++;
            end
            if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) begin
               if (ar_cnt >= ar_dly) bus.M_AXI_ARREADY = 1; else ar_cnt++;
            end
         end
      end
   end

   int aw_hi = 0, w_hi = 0;
   always @(negedge clk) begin
      if (rst_n && bus.M_AXI_AWVALID) aw_hi++;
      if (rst_n && bus.M_AXI_WVALID)  w_hi++;
   end

   // ---------------- transaction-level reference ----------------
   logic m_busy = 0, m_is_wr = 0, m_aw_pend = 0, m_w_pend = 0, m_ar_pend = 0;
   logic m_rsp_pend = 0, m_rsp_write = 0, m_timeout = 0;
   logic [31:0] m_rsp_rdata = '0, m_wdata = '0;
   logic [1:0]  m_rsp_resp = '0;
   logic [7:0]  m_addr = '0;
   logic [3:0]  m_wstrb = '0;
   int          m_wait = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy = 0; m_aw_pend = 0; m_w_pend = 0; m_ar_pend = 0;
         m_rsp_pend = 0; m_timeout = 0; m_wait = 0;
      end
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy && !m_rsp_pend));
      chk("awvalid",   32'(bus.M_AXI_AWVALID), 32'(m_aw_pend));
      chk("wvalid",    32'(bus.M_AXI_WVALID),  32'(m_w_pend));
      chk("arvalid",   32'(bus.M_AXI_ARVALID), 32'(m_ar_pend));
      chk("bready",    32'(bus.M_AXI_BREADY),  32'(m_busy && m_is_wr));
      chk("rready",    32'(bus.M_AXI_RREADY),  32'(m_busy && !m_is_wr));
      chk("rsp_valid", 32'(bus.rsp_valid),     32'(m_rsp_pend));
      chk("timeout",   32'(timeout_err),       32'(m_timeout));
      chk("prot",      32'({bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}), 32'(0));
      if (m_aw_pend) chk("awaddr", 32'(bus.M_AXI_AWADDR), 32'(m_addr));
      if (m_ar_pend) chk("araddr", 32'(bus.M_AXI_ARADDR), 32'(m_addr));
      if (m_w_pend) begin
         chk("wdata", bus.M_AXI_WDATA, m_wdata);
         chk("wstrb", 32'(bus.M_AXI_WSTRB), 32'(m_wstrb));
      end
      if (m_rsp_pend) begin
         chk("rsp_write", 32'(bus.rsp_write), 32'(m_rsp_write));
         chk("rsp_rdata", bus.rsp_rdata, m_rsp_rdata);
         chk("rsp_resp",  32'(bus.rsp_resp), 32'(m_rsp_resp));
      end
      if (rst_n) begin
         if (!m_busy && !m_rsp_pend) begin
            if (bus.cmd_valid) begin
               m_busy = 1; m_is_wr = bus.cmd_write; m_wait = 0;
               m_aw_pend = bus.cmd_write; m_w_pend = bus.cmd_write; m_ar_pend = !bus.cmd_write;
               m_addr = bus.cmd_addr; m_wdata = bus.cmd_wdata; m_wstrb = bus.cmd_wstrb;
            end
         end else if (m_busy) begin
            m_wait++;
            if (m_wait >= TMO) m_timeout = 1;
            if (m_aw_pend && bus.M_AXI_AWREADY) m_aw_pend = 0;
            if (m_w_pend && bus.M_AXI_WREADY)   m_w_pend = 0;
            if (m_ar_pend && bus.M_AXI_ARREADY) m_ar_pend = 0;
            if (m_is_wr ? bus.M_AXI_BVALID : bus.M_AXI_RVALID) begin
               m_busy = 0; m_aw_pend = 0; m_w_pend = 0; m_ar_pend = 0;
               m_rsp_pend = 1; m_rsp_write = m_is_wr;
               m_rsp_rdata = m_is_wr ? 32'h0 : bus.M_AXI_RDATA;
               m_rsp_resp  = m_is_wr ? bus.M_AXI_BRESP : bus.M_AXI_RRESP;
            end
         end else if (bus.rsp_ready) m_rsp_pend = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      logic got;
      got = 0;
      bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = a;
      bus.cmd_wdata = d; bus.cmd_wstrb = s;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin got = 1; break; end
      end
      if (!got) chk("cmd_accept_wait", 32'(bus.cmd_ready), 32'(1));
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      bus.cmd_valid = 0;
   endtask

   task automatic wait_rsp(input string tag, input int max_cyc, output int lat);
      lat = -1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin lat = cyc - acc_cyc; break; end
      end
      if (lat < 0) chk({tag, "_rsp_wait"}, 32'(bus.rsp_valid), 32'(1));
   endtask

   initial begin
      int lat, b0, aw0, w0, awh0, wh0;
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
      bus.cmd_wdata = 0; bus.cmd_wstrb = 0; bus.rsp_ready = 1;

      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
      chk("rst_valids", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                             bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.rsp_valid, timeout_err}), 32'(0));
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;

      // 1: write, always-ready slave
      aw0 = n_aw; w0 = n_w;
      do_cmd(1, 8'h08, 32'hDEADBEEF, 4'hF);
      wait_rsp("t1", 50, lat);
      chk("t1_latency", 32'(lat), 32'(3));
      chk("t1_rsp_write", 32'(bus.rsp_write), 32'(1));
      chk("t1_rsp_resp", 32'(bus.rsp_resp), 32'(RESP_OKAY));
      chk("t1_aw_count", 32'(n_aw - aw0), 32'(1));
      chk("t1_w_count", 32'(n_w - w0), 32'(1));
      chk("t1_awaddr", 32'(s_awaddr), 32'h08);
      @(posedge clk); #1;

      // 2: readback
      do_cmd(0, 8'h08, 32'h0, 4'h0);
      wait_rsp("t2", 50, lat);
      chk("t2_latency", 32'(lat), 32'(3));
      chk("t2_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      chk("t2_rsp_write", 32'(bus.rsp_write), 32'(0));
      chk("t2_araddr", 32'(s_araddr), 32'h08);
      @(posedge clk); #1;

      // partial-strobe write then readback
      do_cmd(1, 8'h08, 32'hAABBCCDD, 4'b0101);
      wait_rsp("t2s_w", 50, lat);
      @(posedge clk); #1;
      do_cmd(0, 8'h08, 32'h0, 4'h0);
      wait_rsp("t2s_r", 50, lat);
      chk("t2s_rdata", bus.rsp_rdata, 32'hDEBBBEDD);
      @(posedge clk); #1;

      // 3: AWREADY late, W first
      aw_dly = 5; w_dly = 2;
      aw0 = n_aw; w0 = n_w; b0 = n_b; awh0 = aw_hi; wh0 = w_hi;
      do_cmd(1, 8'h10, 32'h12345678, 4'hF);
      wait_rsp("t3", 50, lat);
      chk("t3_latency", 32'(lat), 32'(8));
      chk("t3_awvalid_cycles", 32'(aw_hi - awh0), 32'(6));
      chk("t3_wvalid_cycles", 32'(w_hi - wh0), 32'(3));
      @(posedge clk); #1;
      repeat (3) @(negedge clk);
      chk("t3_aw_count", 32'(n_aw - aw0), 32'(1));
      chk("t3_w_count", 32'(n_w - w0), 32'(1));
      chk("t3_b_count", 32'(n_b - b0), 32'(1));
      aw_dly = 0; w_dly = 0;
      @(posedge clk); #1;

      // 4: SLVERR read, response held off for 3 cycles
      r_resp_cfg = RESP_SLVERR; bus.rsp_ready = 0;
      do_cmd(0, 8'h10, 32'h0, 4'h0);
      wait_rsp("t4", 50, lat);
      chk("t4_latency", 32'(lat), 32'(3));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(bus.rsp_valid), 32'(1));
         chk("t4_hold_rdata", bus.rsp_rdata, 32'h12345678);
         chk("t4_hold_resp", 32'(bus.rsp_resp), 32'(RESP_SLVERR));
         chk("t4_hold_cmd_ready", 32'(bus.cmd_ready), 32'(0));
      end
      @(posedge clk); #1 bus.rsp_ready = 1; r_resp_cfg = RESP_OKAY;
      @(negedge clk);
      chk("t4_valid_before_edge", 32'(bus.rsp_valid), 32'(1));
      @(negedge clk);
      chk("t4_released", 32'({bus.rsp_valid, bus.cmd_ready}), 32'(2'b01));
      @(posedge clk); #1;

      // 5: ARREADY withheld, watchdog fires, late completion
      ar_dly = 1000;
      do_cmd(0, 8'h08, 32'h0, 4'h0);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (timeout_err) begin lat = cyc - acc_cyc; break; end
      end
      chk("t5_timeout_cycle", 32'(lat), 32'(17));
      chk("t5_arvalid_held", 32'(bus.M_AXI_ARVALID), 32'(1));
      ar_dly = 0;
      wait_rsp("t5", 60, lat);
      chk("t5_rdata", bus.rsp_rdata, 32'hDEBBBEDD);
      chk("t5_resp", 32'(bus.rsp_resp), 32'(RESP_OKAY));
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_timeout_sticky", 32'(timeout_err), 32'(1));
      @(posedge clk); #1;

      // 6: asynchronous reset mid-WR
      aw_dly = 1000; b0 = n_b;
      do_cmd(1, 8'h20, 32'hCAFEF00D, 4'hF);
      chk("t6_pre_awvalid", 32'(bus.M_AXI_AWVALID), 32'(1));
      #2 rst_n = 0;
      #1;
      chk("t6_rst_outputs", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                 bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.rsp_valid, timeout_err}), 32'(0));
      chk("t6_rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
      aw_dly = 0;
      @(posedge clk); @(posedge clk); #3 rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t6_no_stale_rsp", 32'({bus.rsp_valid, bus.cmd_ready}), 32'(2'b01));
      end
      chk("t6_no_b", 32'(n_b - b0), 32'(0));
      @(posedge clk); #1;
      do_cmd(1, 8'h20, 32'hCAFEF00D, 4'hF);
      wait_rsp("t6_w", 50, lat);
      @(posedge clk); #1;
      do_cmd(0, 8'h20, 32'h0, 4'h0);
      wait_rsp("t6_r", 50, lat);
      chk("t6_rdata", bus.rsp_rdata, 32'hCAFEF00D);
      chk("t6_latency", 32'(lat), 32'(3));
      @(posedge clk); #1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit actual=running required=finished");
      $fatal(1, "time limit");
   end

endmodule
